mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 206 ++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory + writeback stage: issues aligned load/store requests, waits for
// grant and load data, and drives the register file write port directly.
module mem_wb_stage (
  input  logic        clk_pi,
  input  logic        reset_pi,
  input  logic        ex_valid_pi,
  output logic        ex_ready_po,
  input  logic [4:0]  ex_rd_pi,
  input  logic        ex_regwrite_pi,
  input  logic        ex_is_load_pi,
  input  logic        ex_is_store_pi,
  input  logic [2:0]  ex_funct3_pi,
  input  logic [31:0] ex_alu_result_pi,
  input  logic [31:0] ex_store_data_pi,
  output logic        mem_req_po,
  output logic        mem_we_po,
  output logic [31:0] mem_addr_po,
  output logic [31:0] mem_wdata_po,
  output logic [3:0]  mem_wstrb_po,
  input  logic        mem_gnt_pi,
  input  logic        mem_rvalid_pi,
  input  logic [31:0] mem_rdata_pi,
  output logic [4:0]  destReg_po,
  output logic        we_po,
  output logic [31:0] writeData_po,
  output logic        misaligned_po
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [XLEN-1:0]     mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [REG_AW-1:0]   dest_q, dest_d;
  logic                we_q, we_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic                misaligned_q, misaligned_d;
  logic [REG_AW-1:0]   pend_rd_q, pend_rd_d;
  logic [2:0]          pend_f3_q, pend_f3_d;
  logic [1:0]          pend_off_q, pend_off_d;

  logic                accept;
  logic                is_mem;
  logic                illegal_f3;
  logic                misalign;
  logic [1:0]          off;
  logic [XLEN-1:0]     st_wdata;
  logic [STRB_W-1:0]   st_wstrb;
  logic [XLEN-1:0]     ld_data;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;

  assign ex_ready_po = (state_q == IDLE) && !reset_pi;

  // Decode of the incoming op: legality, alignment and store lane placement
  always_comb begin
    accept     = ex_valid_pi && ex_ready_po;
    is_mem     = ex_is_load_pi || ex_is_store_pi;
    off        = ex_alu_result_pi[1:0];
    if (ex_is_load_pi) begin
      illegal_f3 = (ex_funct3_pi == 3'd3) || (ex_funct3_pi == 3'd6) ||
                   (ex_funct3_pi == 3'd7);
    end else begin
      illegal_f3 = (ex_funct3_pi > 3'd2);
    end
    misalign   = ((ex_funct3_pi[1:0] == 2'd1) && off[0]) ||
                 ((ex_funct3_pi[1:0] == 2'd2) && (off != 2'd0));
    st_wdata   = ex_store_data_pi;
    st_wstrb   = 4'b1111;
    case (ex_funct3_pi[1:0])
      2'd0: begin
        st_wdata = {4{ex_store_data_pi[7:0]}};
        st_wstrb = STRB_W'(4'b0001 << off);
      end
      2'd1: begin
        st_wdata = {2{ex_store_data_pi[15:0]}};
        st_wstrb = off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = ex_store_data_pi;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load data extraction from the returned word using the pending op info
  always_comb begin
    ld_byte = 8'(mem_rdata_pi >> {pend_off_q, 3'b000});
    ld_half = pend_off_q[1] ? mem_rdata_pi[31:16] : mem_rdata_pi[15:0];
    case (pend_f3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata_pi;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    dest_d       = dest_q;
    we_d         = 1'b0;
    wdata_d      = wdata_q;
    misaligned_d = 1'b0;
    pend_rd_d    = pend_rd_q;
    pend_f3_d    = pend_f3_q;
    pend_off_d   = pend_off_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            dest_d  = ex_rd_pi;
            wdata_d = ex_alu_result_pi;
            we_d    = ex_regwrite_pi && (ex_rd_pi != '0);
          end else if (illegal_f3 || misalign) begin
            misaligned_d = 1'b1;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = !ex_is_load_pi;
            mem_addr_d  = {ex_alu_result_pi[31:2], 2'b00};
            mem_wdata_d = ex_is_load_pi ? '0 : st_wdata;
            mem_wstrb_d = ex_is_load_pi ? '0 : st_wstrb;
            pend_rd_d   = ex_rd_pi;
            pend_f3_d   = ex_funct3_pi;
            pend_off_d  = off;
          end
        end
      end
      REQ: begin
        if (mem_gnt_pi) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = mem_we_q ? IDLE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mem_rvalid_pi) begin
          state_d = IDLE;
          dest_d  = pend_rd_q;
          wdata_d = ld_data;
          we_d    = (pend_rd_q != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      dest_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      misaligned_q <= 1'b0;
      pend_rd_q    <= '0;
      pend_f3_q    <= '0;
      pend_off_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      dest_q       <= dest_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      misaligned_q <= misaligned_d;
      pend_rd_q    <= pend_rd_d;
      pend_f3_q    <= pend_f3_d;
      pend_off_q   <= pend_off_d;
    end
  end

  assign mem_req_po    = mem_req_q;
  assign mem_we_po     = mem_we_q;
  assign mem_addr_po   = mem_addr_q;
  assign mem_wdata_po  = mem_wdata_q;
  assign mem_wstrb_po  = mem_wstrb_q;
  assign destReg_po    = dest_q;
  assign we_po         = we_q;
  assign writeData_po  = wdata_q;
  assign misaligned_po = misaligned_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk_pi = 1'b0;
  logic        reset_pi;
  logic        ex_valid_pi;
  logic        ex_ready_po;
  logic [4:0]  ex_rd_pi;
  logic        ex_regwrite_pi;
  logic        ex_is_load_pi;
  logic        ex_is_store_pi;
  logic [2:0]  ex_funct3_pi;
  logic [31:0] ex_alu_result_pi;
  logic [31:0] ex_store_data_pi;
  logic        mem_req_po;
  logic        mem_we_po;
  logic [31:0] mem_addr_po;
  logic [31:0] mem_wdata_po;
  logic [3:0]  mem_wstrb_po;
  logic        mem_gnt_pi;
  logic        mem_rvalid_pi;
  logic [31:0] mem_rdata_pi;
  logic [4:0]  destReg_po;
  logic        we_po;
  logic [31:0] writeData_po;
  logic        misaligned_po;

  int n_checks = 0;
  int n_pass   = 0;

  mem_wb_stage dut (
    .clk_pi(clk_pi), .reset_pi(reset_pi),
    .ex_valid_pi(ex_valid_pi), .ex_ready_po(ex_ready_po),
    .ex_rd_pi(ex_rd_pi), .ex_regwrite_pi(ex_regwrite_pi),
    .ex_is_load_pi(ex_is_load_pi), .ex_is_store_pi(ex_is_store_pi),
    .ex_funct3_pi(ex_funct3_pi), .ex_alu_result_pi(ex_alu_result_pi),
    .ex_store_data_pi(ex_store_data_pi),
    .mem_req_po(mem_req_po), .mem_we_po(mem_we_po), .mem_addr_po(mem_addr_po),
    .mem_wdata_po(mem_wdata_po), .mem_wstrb_po(mem_wstrb_po),
    .mem_gnt_pi(mem_gnt_pi), .mem_rvalid_pi(mem_rvalid_pi),
    .mem_rdata_pi(mem_rdata_pi),
    .destReg_po(destReg_po), .we_po(we_po), .writeData_po(writeData_po),
    .misaligned_po(misaligned_po)
  );

  always #5 clk_pi = ~clk_pi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_pi);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                       input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sd);
    ex_valid_pi      = v;
    ex_rd_pi         = rd;
    ex_regwrite_pi   = rw;
    ex_is_load_pi    = ld;
    ex_is_store_pi   = st;
    ex_funct3_pi     = f3;
    ex_alu_result_pi = alu;
    ex_store_data_pi = sd;
  endtask

  task automatic idle_in();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  // Load with immediate grant and response; checks request and writeback
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] exp);
    drive(1'b1, rd, 1'b0, 1'b1, 1'b0, f3, addr, 32'd0);
    tick();
    idle_in();
    chk({tag, "_req"}, 32'(mem_req_po), 32'd1);
    chk({tag, "_addr"}, mem_addr_po, {addr[31:2], 2'b00});
    chk({tag, "_rdy_busy"}, 32'(ex_ready_po), 32'd0);
    mem_gnt_pi = 1'b1;
    tick();
    mem_gnt_pi = 1'b0;
    chk({tag, "_req_drop"}, 32'(mem_req_po), 32'd0);
    mem_rvalid_pi = 1'b1;
    mem_rdata_pi  = rdata;
    tick();
    mem_rvalid_pi = 1'b0;
    chk({tag, "_we"}, 32'(we_po), 32'd1);
    chk({tag, "_rd"}, 32'(destReg_po), 32'(rd));
    chk({tag, "_data"}, writeData_po, exp);
    chk({tag, "_rdy"}, 32'(ex_ready_po), 32'd1);
    tick();
    chk({tag, "_we_pulse"}, 32'(we_po), 32'd0);
  endtask

  initial begin
    reset_pi      = 1'b1;
    mem_gnt_pi    = 1'b0;
    mem_rvalid_pi = 1'b0;
    mem_rdata_pi  = 32'd0;
    idle_in();
    tick();
    tick();
    chk("rst_ready", 32'(ex_ready_po), 32'd0);
    chk("rst_we", 32'(we_po), 32'd0);
    chk("rst_req", 32'(mem_req_po), 32'd0);
    chk("rst_wdata", writeData_po, 32'd0);
    chk("rst_addr", mem_addr_po, 32'd0);
    chk("rst_mis", 32'(misaligned_po), 32'd0);
    reset_pi = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ex_ready_po), 32'd1);

    // Back-to-back ALU ops, rd=0 suppressed
    drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 32'h11, 32'd0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h22, 32'd0);
    chk("alu1_we", 32'(we_po), 32'd1);
    chk("alu1_rd", 32'(destReg_po), 32'd5);
    chk("alu1_data", writeData_po, 32'h11);
    tick();
    drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 3'd0, 32'h33, 32'd0);
    chk("alu_rd0_we", 32'(we_po), 32'd0);
    tick();
    idle_in();
    chk("alu3_we", 32'(we_po), 32'd1);
    chk("alu3_rd", 32'(destReg_po), 32'd6);
    chk("alu3_data", writeData_po, 32'h33);
    tick();
    chk("alu3_pulse", 32'(we_po), 32'd0);

    // ALU op with regwrite low
    drive(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 3'd0, 32'h55, 32'd0);
    tick();
    idle_in();
    chk("alu_norw_we", 32'(we_po), 32'd0);

    // Load extraction
    do_load("lb",  5'd7, 3'd0, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu", 5'd8, 3'd4, 32'h103, 32'h80FF_0000, 32'h0000_0080);
    do_load("lh",  5'd9, 3'd1, 32'h102, 32'h80FF_0000, 32'hFFFF_80FF);
    do_load("lhu", 5'd10, 3'd5, 32'h100, 32'h1234_9ABC, 32'h0000_9ABC);
    do_load("lw",  5'd11, 3'd2, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb1", 5'd12, 3'd0, 32'h101, 32'h0000_7F00, 32'h0000_007F);

    // SH with grant delayed three cycles; regwrite ignored
    drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 3'd1, 32'h202, 32'h1234_ABCD);
    tick();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      chk("sh_req", 32'(mem_req_po), 32'd1);
      chk("sh_we", 32'(mem_we_po), 32'd1);
      chk("sh_addr", mem_addr_po, 32'h200);
      chk("sh_wdata", mem_wdata_po, 32'hABCD_ABCD);
      chk("sh_wstrb", 32'(mem_wstrb_po), 32'hC);
      chk("sh_no_wb", 32'(we_po), 32'd0);
      if (i < 2) tick();
    end
    mem_gnt_pi = 1'b1;
    tick();
    mem_gnt_pi = 1'b0;
    chk("sh_done_req", 32'(mem_req_po), 32'd0);
    chk("sh_done_rdy", 32'(ex_ready_po), 32'd1);
    chk("sh_done_wb", 32'(we_po), 32'd0);

    // SB lane placement
    drive(1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 3'd0, 32'h302, 32'h0000_0055);
    tick();
    idle_in();
    chk("sb_wdata", mem_wdata_po, 32'h5555_5555);
    chk("sb_wstrb", 32'(mem_wstrb_po), 32'h4);
    chk("sb_addr", mem_addr_po, 32'h300);
    mem_gnt_pi = 1'b1;
    tick();
    mem_gnt_pi = 1'b0;

    // SW full word
    drive(1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 3'd2, 32'h408, 32'hCAFE_F00D);
    tick();
    idle_in();
    chk("sw_wdata", mem_wdata_po, 32'hCAFE_F00D);
    chk("sw_wstrb", 32'(mem_wstrb_po), 32'hF);
    mem_gnt_pi = 1'b1;
    tick();
    mem_gnt_pi = 1'b0;
    chk("sw_wb", 32'(we_po), 32'd0);

    // Misaligned LW
    drive(1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 3'd2, 32'h301, 32'd0);
    tick();
    idle_in();
    chk("mis_pulse", 32'(misaligned_po), 32'd1);
    chk("mis_req", 32'(mem_req_po), 32'd0);
    chk("mis_we", 32'(we_po), 32'd0);
    chk("mis_rdy", 32'(ex_ready_po), 32'd1);
    tick();
    chk("mis_pulse_end", 32'(misaligned_po), 32'd0);
    chk("mis_req2", 32'(mem_req_po), 32'd0);

    // Illegal store funct3
    drive(1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 3'd3, 32'h300, 32'd0);
    tick();
    idle_in();
    chk("ill_st_mis", 32'(misaligned_po), 32'd1);
    chk("ill_st_req", 32'(mem_req_po), 32'd0);
    tick();

    // Reset in WAIT_RESP abandons the load
    drive(1'b1, 5'd13, 1'b1, 1'b1, 1'b0, 3'd2, 32'h400, 32'd0);
    tick();
    idle_in();
    mem_gnt_pi = 1'b1;
    tick();
    mem_gnt_pi = 1'b0;
    reset_pi = 1'b1;
    #1;
    chk("rst_mid_rdy", 32'(ex_ready_po), 32'd0);
    tick();
    reset_pi = 1'b0;
    #1;
    chk("rst_mid_rdy_after", 32'(ex_ready_po), 32'd1);
    tick();
    tick();
    mem_rvalid_pi = 1'b1;
    mem_rdata_pi  = 32'h5A5A_5A5A;
    tick();
    mem_rvalid_pi = 1'b0;
    chk("stray_rvalid_we", 32'(we_po), 32'd0);
    chk("stray_rvalid_rdy", 32'(ex_ready_po), 32'd1);
    drive(1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 3'd0, 32'h44, 32'd0);
    tick();
    idle_in();
    chk("after_rst_we", 32'(we_po), 32'd1);
    chk("after_rst_rd", 32'(destReg_po), 32'd11);
    chk("after_rst_data", writeData_po, 32'h44);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
